// File: rtl/comparison_arbiter.sv
// comparison_arbiter
//   Shares one combinational comparison unit among NUM_REQ requesters.
//   Round-robin arbitration on the request side, valid/ready on both sides,
//   two-stage pipeline: operand register (p1) -> result register (p2).
//   Each result is returned tagged with the id of the requester that issued it.
//   Optional feature macro: CMP_ARB_PERF_EN adds perf_issued / perf_stall
//   counters and their output ports.
module comparison_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FUNCTION_BITS = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int ID_BITS       = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*FUNCTION_BITS-1:0] req_fn,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]     req_data0,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]     req_data1,
  output logic [FUNCTION_BITS-1:0]         cu_fn,
  output logic [BIT_WIDTH-1:0]             cu_data_in0,
  output logic [BIT_WIDTH-1:0]             cu_data_in1,
  input  logic [BIT_WIDTH-1:0]             cu_data_out,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [BIT_WIDTH-1:0]             rsp_data,
  output logic [ID_BITS-1:0]               rsp_id,
  output logic                             busy
`ifdef CMP_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_issued,
  output logic [31:0]                      perf_stall
`endif
);

  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

  // Unpacked views of the packed request buses
  logic [FUNCTION_BITS-1:0] w_fn_arr  [NUM_REQ];
  logic [BIT_WIDTH-1:0]     w_d0_arr  [NUM_REQ];
  logic [BIT_WIDTH-1:0]     w_d1_arr  [NUM_REQ];
  logic                     w_vld_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_fn_arr[g]  = req_fn[g*FUNCTION_BITS +: FUNCTION_BITS];
    assign w_d0_arr[g]  = req_data0[g*BIT_WIDTH +: BIT_WIDTH];
    assign w_d1_arr[g]  = req_data1[g*BIT_WIDTH +: BIT_WIDTH];
    assign w_vld_arr[g] = req_valid[g];
  end

  // Operand stage (p1) state
  logic                     r_vld_p1;
  logic [FUNCTION_BITS-1:0] r_fn_p1;
  logic [BIT_WIDTH-1:0]     r_d0_p1;
  logic [BIT_WIDTH-1:0]     r_d1_p1;
  logic [ID_BITS-1:0]       r_id_p1;

  // Result stage (p2) state
  logic                     r_vld_p2;
  logic [BIT_WIDTH-1:0]     r_data_p2;
  logic [ID_BITS-1:0]       r_id_p2;

  // Round-robin pointer: id of the most recently granted requester
  logic [ID_BITS-1:0]       r_rr_ptr;

  logic                     w_rsp_adv;
  logic                     w_op_adv;
  logic                     w_xfer;
  logic [NUM_REQ-1:0]       w_grant;
  logic [ID_BITS-1:0]       w_grant_id;
  logic [ID_BITS-1:0]       w_cand;

  // A stage may advance when its downstream slot is empty or being emptied
  assign w_rsp_adv = !r_vld_p2 || rsp_ready;
  assign w_op_adv  = !r_vld_p1 || w_rsp_adv;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    w_xfer     = 1'b0;
    w_grant    = '0;
    w_grant_id = '0;
    w_cand     = r_rr_ptr;
    if (w_op_adv) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = (w_cand == LAST_ID) ? '0 : w_cand + 1'b1;
        if (!w_xfer && w_vld_arr[w_cand]) begin
          w_xfer     = 1'b1;
          w_grant_id = w_cand;
          w_grant    = NUM_REQ'(1) << w_cand;
        end
      end
    end
  end

  // A grant is only ever issued to a valid requester, so grant == transfer
  assign req_ready = w_grant;

  // ---- stage p0 -> p1: capture the granted request into the operand register
  // Operand register and arbitration pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_fn_p1  <= '0;
      r_d0_p1  <= '0;
      r_d1_p1  <= '0;
      r_id_p1  <= '0;
      r_rr_ptr <= LAST_ID;
    end else begin
      if (w_xfer) begin
        r_vld_p1 <= 1'b1;
        r_fn_p1  <= w_fn_arr[w_grant_id];
        r_d0_p1  <= w_d0_arr[w_grant_id];
        r_d1_p1  <= w_d1_arr[w_grant_id];
        r_id_p1  <= w_grant_id;
        r_rr_ptr <= w_grant_id;
      end else if (w_rsp_adv) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  // Idle operand stage presents zeros to the comparison unit
  assign cu_fn       = r_vld_p1 ? r_fn_p1 : '0;
  assign cu_data_in0 = r_vld_p1 ? r_d0_p1 : '0;
  assign cu_data_in1 = r_vld_p1 ? r_d1_p1 : '0;

  // ---- stage p1 -> p2: capture the comparison unit result
  // Result register; held stable while the consumer applies backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_id_p2   <= '0;
    end else if (r_vld_p1 && w_rsp_adv) begin
      r_vld_p2  <= 1'b1;
      r_data_p2 <= cu_data_out;
      r_id_p2   <= r_id_p1;
    end else if (rsp_ready) begin
      r_vld_p2  <= 1'b0;
    end
  end

  assign rsp_valid = r_vld_p2;
  assign rsp_data  = r_data_p2;
  assign rsp_id    = r_id_p2;
  assign busy      = r_vld_p1 | r_vld_p2;

`ifdef CMP_ARB_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_xfer) r_perf_issued <= r_perf_issued + 32'd1;
      if (r_vld_p2 && !rsp_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_comparison_arbiter.sv
// tb_comparison_arbiter
//   Directed bench for comparison_arbiter. The comparison unit is emulated
//   locally (0 EQ, 1 NE, 2 GT, 3 GE, 4 LT, 5 LE, others return 0).
//   Honours CMP_ARB_PERF_EN when defined.
module tb_comparison_arbiter;
  localparam int NR = 4;
  localparam int FB = 4;
  localparam int BW = 32;
  localparam int IB = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*FB-1:0] req_fn;
  logic [NR*BW-1:0] req_data0;
  logic [NR*BW-1:0] req_data1;
  logic [FB-1:0]    cu_fn;
  logic [BW-1:0]    cu_data_in0;
  logic [BW-1:0]    cu_data_in1;
  logic [BW-1:0]    cu_data_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [BW-1:0]    rsp_data;
  logic [IB-1:0]    rsp_id;
  logic             busy;
`ifdef CMP_ARB_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
`endif

  logic [FB-1:0] t_fn [NR];
  logic [BW-1:0] t_d0 [NR];
  logic [BW-1:0] t_d1 [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_fn[g*FB +: FB]    = t_fn[g];
    assign req_data0[g*BW +: BW] = t_d0[g];
    assign req_data1[g*BW +: BW] = t_d1[g];
  end

  always #5 clk = ~clk;

  comparison_arbiter #(
    .NUM_REQ(NR), .FUNCTION_BITS(FB), .BIT_WIDTH(BW), .ID_BITS(IB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_data0(req_data0), .req_data1(req_data1),
    .cu_fn(cu_fn), .cu_data_in0(cu_data_in0), .cu_data_in1(cu_data_in1),
    .cu_data_out(cu_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef CMP_ARB_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  // Comparison unit emulation
  always_comb begin
    cu_data_out = '0;
    case (cu_fn)
      4'd0: cu_data_out[0] = (cu_data_in0 == cu_data_in1);
      4'd1: cu_data_out[0] = (cu_data_in0 != cu_data_in1);
      4'd2: cu_data_out[0] = (cu_data_in0 >  cu_data_in1);
      4'd3: cu_data_out[0] = (cu_data_in0 >= cu_data_in1);
      4'd4: cu_data_out[0] = (cu_data_in0 <  cu_data_in1);
      4'd5: cu_data_out[0] = (cu_data_in0 <= cu_data_in1);
      default: cu_data_out = '0;
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int            id;
    logic [FB-1:0] fn;
    logic [BW-1:0] d0;
    logic [BW-1:0] d1;
    logic [NR-1:0] ready;
    logic [BW-1:0] data;
  } vec_t;

  vec_t vt [8];

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      t_fn[i] = '0; t_d0[i] = '0; t_d1[i] = '0;
    end

    vt[0] = '{1, 4'd2, 32'd7, 32'd3, 4'b0010, 32'd1};
    vt[1] = '{0, 4'd1, 32'd5, 32'd5, 4'b0001, 32'd0};
    vt[2] = '{2, 4'd4, 32'd2, 32'd9, 4'b0100, 32'd1};
    vt[3] = '{3, 4'd9, 32'd4, 32'd1, 4'b1000, 32'd0};
    vt[4] = '{1, 4'd0, 32'd6, 32'd6, 4'b0010, 32'd1};
    vt[5] = '{3, 4'd3, 32'd5, 32'd5, 4'b1000, 32'd1};
    vt[6] = '{0, 4'd5, 32'd9, 32'd2, 4'b0001, 32'd0};
    vt[7] = '{2, 4'd2, 32'd7, 32'd7, 4'b0100, 32'd0};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  rsp_data,       32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);
    chk("rst_cu_fn",     32'(cu_fn),     32'h0);
    chk("rst_cu_d0",     cu_data_in0,    32'h0);
    chk("rst_cu_d1",     cu_data_in1,    32'h0);

    // Single-requester vectors through the comparison unit
    for (int e = 0; e < 8; e++) begin
      t_fn[vt[e].id] = vt[e].fn;
      t_d0[vt[e].id] = vt[e].d0;
      t_d1[vt[e].id] = vt[e].d1;
      req_valid = NR'(1) << vt[e].id;
      settle();
      chk("vec_req_ready", 32'(req_ready), 32'(vt[e].ready));
      tick();
      req_valid = '0;
      settle();
      chk("vec_cu_fn", 32'(cu_fn), 32'(vt[e].fn));
      chk("vec_cu_d0", cu_data_in0, vt[e].d0);
      chk("vec_cu_d1", cu_data_in1, vt[e].d1);
      tick();
      settle();
      chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("vec_rsp_data",  rsp_data,       vt[e].data);
      chk("vec_rsp_id",    32'(rsp_id),    32'(vt[e].id));
      tick();
    end

    // All requesters valid: grants rotate 0,1,2,3,... with one result per cycle
    do_reset();
    for (int i = 0; i < NR; i++) begin
      t_fn[i] = 4'd4; t_d0[i] = 32'(i); t_d1[i] = 32'd2;
    end
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % NR));
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_rsp_id",    32'(rsp_id),    32'((k - 2) % NR));
        chk("rr_rsp_data",  rsp_data,       ((k - 2) % NR < 2) ? 32'd1 : 32'd0);
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
    settle();
    chk("rr_drain_busy", 32'(busy), 32'h0);

    // Backpressure with both stages full
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    settle();
    chk("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    settle();
    chk("bp_grant1", 32'(req_ready), 32'h2);
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id",    32'(rsp_id),    32'h0);
      chk("bp_rsp_data",  rsp_data,       32'h1);
      chk("bp_cu_d0",     cu_data_in0,    32'h1);
      chk("bp_busy",      32'(busy),      32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_rel_grant", 32'(req_ready), 32'h4);
    chk("bp_rel_id0",   32'(rsp_id),    32'h0);
    tick();
    req_valid = '0;
    settle();
    chk("bp_rel_valid1", 32'(rsp_valid), 32'h1);
    chk("bp_rel_id1",    32'(rsp_id),    32'h1);
    chk("bp_rel_data1",  rsp_data,       32'h1);
    tick();
    settle();
    chk("bp_rel_valid2", 32'(rsp_valid), 32'h1);
    chk("bp_rel_id2",    32'(rsp_id),    32'h2);
    chk("bp_rel_data2",  rsp_data,       32'h0);
    tick();
    settle();
    chk("bp_end_valid", 32'(rsp_valid), 32'h0);
    chk("bp_end_busy",  32'(busy),      32'h0);
`ifdef CMP_ARB_PERF_EN
    chk("perf_issued", perf_issued, 32'd3);
    chk("perf_stall",  perf_stall,  32'd3);
`endif

    // Reset with both stages full discards them; next grant restarts at req0
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    tick();
    tick();
    settle();
    chk("mr_full_busy",  32'(busy),      32'h1);
    chk("mr_full_valid", 32'(rsp_valid), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mr_busy",      32'(busy),      32'h0);
    chk("mr_cu_fn",     32'(cu_fn),     32'h0);
    chk("mr_rsp_data",  rsp_data,       32'h0);
    chk("mr_grant",     32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    settle();
    chk("mr_post_valid", 32'(rsp_valid), 32'h1);
    chk("mr_post_id",    32'(rsp_id),    32'h0);
    chk("mr_post_data",  rsp_data,       32'h1);
`ifdef CMP_ARB_PERF_EN
    chk("perf_mr_issued", perf_issued, 32'd1);
    chk("perf_mr_stall",  perf_stall,  32'd0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
